// File: rtl/buf_pingpong_sched_pkg.sv
// Shared types and sizes for the ping-pong buffer scheduler.
//   BUF_NUM     : number of ping-pong buffers (two; pointers are 1 bit)
//   BUF_AW      : width of a per-buffer 128-bit-entry count
//   buf_state_t : lifecycle of one buffer
package buf_sched_pkg;

  localparam int unsigned BUF_NUM = 2;
  localparam int unsigned BUF_AW  = 7;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } buf_state_t;

endpackage

// File: rtl/buf_pingpong_sched_if.sv
// Handshake bundle between the transfer controller / DMA / buffer reader
// (master side) and the ping-pong scheduler (slave side).
//   fill_req/fill_grant/fill_buf/fill_done/fill_words : fill handshake
//   drain_req/drain_grant/drain_buf/drain_words/drain_done : drain handshake
//   abort : synchronous clear of buffer bookkeeping
//   buffer_rw_select/full_cnt/proto_err : status
interface buf_pingpong_sched_if;
  import buf_sched_pkg::*;

  logic              fill_req;
  logic              fill_grant;
  logic              fill_buf;
  logic              fill_done;
  logic [BUF_AW-1:0] fill_words;
  logic              drain_req;
  logic              drain_grant;
  logic              drain_buf;
  logic [BUF_AW-1:0] drain_words;
  logic              drain_done;
  logic              abort;
  logic [1:0]        buffer_rw_select;
  logic [1:0]        full_cnt;
  logic              proto_err;

  modport master (
    output fill_req, fill_done, fill_words, drain_req, drain_done, abort,
    input  fill_grant, fill_buf, drain_grant, drain_buf, drain_words,
           buffer_rw_select, full_cnt, proto_err
  );

  modport slave (
    input  fill_req, fill_done, fill_words, drain_req, drain_done, abort,
    output fill_grant, fill_buf, drain_grant, drain_buf, drain_words,
           buffer_rw_select, full_cnt, proto_err
  );
endinterface

// File: rtl/buf_pingpong_sched_slot.sv
// State and entry count of a single ping-pong buffer.
//   clk, rst       : clock, async active-high reset
//   clr_i          : synchronous clear (abort), dominates all events
//   fill_start_i   : buffer granted to DMA writer
//   fill_end_i     : fill finished; fill_words_i entries written (0 = none)
//   drain_start_i  : buffer granted to reader
//   drain_end_i    : drain finished
//   state_o/count_o: registered state and entry count
module buf_state_slot
  import buf_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              fill_start_i,
  input  logic              fill_end_i,
  input  logic [BUF_AW-1:0] fill_words_i,
  input  logic              drain_start_i,
  input  logic              drain_end_i,
  output buf_state_t        state_o,
  output logic [BUF_AW-1:0] count_o
);

  buf_state_t        state_q, state_d;
  logic [BUF_AW-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clr_i) begin
      state_d = EMPTY;
      count_d = '0;
    end else begin
      if (fill_start_i) state_d = FILLING;
      if (fill_end_i) begin
        // An empty fill hands the buffer straight back without publishing it
        if (fill_words_i != '0) begin
          state_d = FULL;
          count_d = fill_words_i;
        end else begin
          state_d = EMPTY;
        end
      end
      if (drain_start_i) state_d = DRAINING;
      if (drain_end_i) begin
        state_d = EMPTY;
        count_d = '0;
      end
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;

endmodule

// File: rtl/buf_pingpong_sched.sv
// Ping-pong buffer scheduler: grants the two buffers alternately to a DMA
// writer (fill) and a reader (drain) so that drain order equals fill order.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of buf_pingpong_sched_if (handshakes + status)
module buf_pingpong_sched
  import buf_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  buf_pingpong_sched_if.slave   bus
);

  buf_state_t        st  [BUF_NUM];
  logic [BUF_AW-1:0] cnt [BUF_NUM];

  logic              fill_ptr_q, fill_ptr_d;
  logic              drain_ptr_q, drain_ptr_d;
  logic              fill_grant_q, fill_grant_d;
  logic              drain_grant_q, drain_grant_d;
  logic              fill_buf_q, fill_buf_d;
  logic              drain_buf_q, drain_buf_d;
  logic [BUF_AW-1:0] drain_words_q, drain_words_d;
  logic              proto_err_q, proto_err_d;

  logic       filling_any, draining_any;
  logic [1:0] rw_sel, full_sum;
  logic       fill_go, fill_end, drain_go, drain_end;

  always_comb begin
    filling_any  = 1'b0;
    draining_any = 1'b0;
    rw_sel       = '0;
    full_sum     = '0;
    for (int unsigned i = 0; i < BUF_NUM; i++) begin
      if (st[i] == FILLING) begin
        filling_any = 1'b1;
        rw_sel[i]   = 1'b1;
      end
      if (st[i] == DRAINING) draining_any = 1'b1;
      if (st[i] == FULL)     full_sum     = full_sum + 2'd1;
    end
  end

  // Decisions use registered state only, so a buffer released on one edge
  // cannot be re-granted until the following edge.
  assign fill_go   = bus.fill_req  && !bus.abort && !filling_any  && (st[fill_ptr_q]  == EMPTY);
  assign drain_go  = bus.drain_req && !bus.abort && !draining_any && (st[drain_ptr_q] == FULL);
  assign fill_end  = bus.fill_done  && !bus.abort && filling_any;
  assign drain_end = bus.drain_done && !bus.abort && draining_any;

  for (genvar g = 0; g < BUF_NUM; g++) begin : g_slot
    buf_state_slot u_slot (
      .clk           (clk),
      .rst           (rst),
      .clr_i         (bus.abort),
      .fill_start_i  (fill_go   && (fill_ptr_q  == 1'(g))),
      .fill_end_i    (fill_end  && (fill_buf_q  == 1'(g))),
      .fill_words_i  (bus.fill_words),
      .drain_start_i (drain_go  && (drain_ptr_q == 1'(g))),
      .drain_end_i   (drain_end && (drain_buf_q == 1'(g))),
      .state_o       (st[g]),
      .count_o       (cnt[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_ptr_q    <= 1'b0;
      drain_ptr_q   <= 1'b0;
      fill_grant_q  <= 1'b0;
      drain_grant_q <= 1'b0;
      fill_buf_q    <= 1'b0;
      drain_buf_q   <= 1'b0;
      drain_words_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      fill_ptr_q    <= fill_ptr_d;
      drain_ptr_q   <= drain_ptr_d;
      fill_grant_q  <= fill_grant_d;
      drain_grant_q <= drain_grant_d;
      fill_buf_q    <= fill_buf_d;
      drain_buf_q   <= drain_buf_d;
      drain_words_q <= drain_words_d;
      proto_err_q   <= proto_err_d;
    end
  end

  always_comb begin
    fill_ptr_d    = fill_ptr_q;
    drain_ptr_d   = drain_ptr_q;
    fill_grant_d  = 1'b0;
    drain_grant_d = 1'b0;
    fill_buf_d    = fill_buf_q;
    drain_buf_d   = drain_buf_q;
    drain_words_d = drain_words_q;
    proto_err_d   = proto_err_q;
    if (bus.abort) begin
      fill_ptr_d    = 1'b0;
      drain_ptr_d   = 1'b0;
      fill_buf_d    = 1'b0;
      drain_buf_d   = 1'b0;
      drain_words_d = '0;
    end else begin
      if (fill_go) begin
        fill_grant_d = 1'b1;
        fill_buf_d   = fill_ptr_q;
      end
      // Only a published buffer advances the pointer; an empty fill reuses it
      if (fill_end && (bus.fill_words != '0)) fill_ptr_d = ~fill_ptr_q;
      if (drain_go) begin
        drain_grant_d = 1'b1;
        drain_buf_d   = drain_ptr_q;
        drain_words_d = cnt[drain_ptr_q];
      end
      if (drain_end) drain_ptr_d = ~drain_ptr_q;
      if ((bus.fill_done && !filling_any) || (bus.drain_done && !draining_any))
        proto_err_d = 1'b1;
    end
  end

  assign bus.fill_grant       = fill_grant_q;
  assign bus.fill_buf         = fill_buf_q;
  assign bus.drain_grant      = drain_grant_q;
  assign bus.drain_buf        = drain_buf_q;
  assign bus.drain_words      = drain_words_q;
  assign bus.proto_err        = proto_err_q;
  assign bus.buffer_rw_select = rw_sel;
  assign bus.full_cnt         = full_sum;

endmodule

// File: tb/tb_buf_pingpong_sched.sv
module tb_buf_pingpong_sched;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  buf_pingpong_sched_if bus ();

  buf_pingpong_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: buffer states 0=empty 1=filling 2=full 3=draining.
  int m_st [2];
  int m_cnt[2];
  int m_fp, m_dp, m_fb, m_db, m_dw;
  bit m_fg, m_dg, m_pe;
  int o_st [2];
  int o_fp, o_dp, fb_idx, db_idx;
  bit o_fill, o_drain;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = '{0, 0}; m_cnt = '{0, 0};
      m_fp = 0; m_dp = 0; m_fb = 0; m_db = 0; m_dw = 0;
      m_fg = 0; m_dg = 0; m_pe = 0;
    end else begin
      o_st = m_st; o_fp = m_fp; o_dp = m_dp;
      o_fill  = (o_st[0] == 1) || (o_st[1] == 1);
      o_drain = (o_st[0] == 3) || (o_st[1] == 3);
      m_fg = 0; m_dg = 0;
      if (bus.abort) begin
        m_st = '{0, 0}; m_cnt = '{0, 0};
        m_fp = 0; m_dp = 0; m_fb = 0; m_db = 0; m_dw = 0;
      end else begin
        if (bus.fill_done) begin
          if (!o_fill) m_pe = 1;
          else begin
            fb_idx = (o_st[0] == 1) ? 0 : 1;
            if (bus.fill_words > 0) begin
              m_st[fb_idx] = 2; m_cnt[fb_idx] = int'(bus.fill_words); m_fp = 1 - o_fp;
            end else m_st[fb_idx] = 0;
          end
        end
        if (bus.drain_done) begin
          if (!o_drain) m_pe = 1;
          else begin
            db_idx = (o_st[0] == 3) ? 0 : 1;
            m_st[db_idx] = 0; m_cnt[db_idx] = 0; m_dp = 1 - o_dp;
          end
        end
        if (bus.fill_req && !o_fill && o_st[o_fp] == 0) begin
          m_fg = 1; m_fb = o_fp; m_st[o_fp] = 1;
        end
        if (bus.drain_req && !o_drain && o_st[o_dp] == 2) begin
          m_dg = 1; m_db = o_dp; m_dw = m_cnt[o_dp]; m_st[o_dp] = 3;
        end
      end
    end
  end

  function automatic int exp_rw();
    return ((m_st[1] == 1) ? 2 : 0) + ((m_st[0] == 1) ? 1 : 0);
  endfunction

  function automatic int exp_full();
    return ((m_st[0] == 2) ? 1 : 0) + ((m_st[1] == 2) ? 1 : 0);
  endfunction

  always @(negedge clk) begin
    check("fill_grant",  32'(bus.fill_grant),       32'(m_fg));
    check("fill_buf",    32'(bus.fill_buf),         32'(m_fb));
    check("drain_grant", 32'(bus.drain_grant),      32'(m_dg));
    check("drain_buf",   32'(bus.drain_buf),        32'(m_db));
    check("drain_words", 32'(bus.drain_words),      32'(m_dw));
    check("proto_err",   32'(bus.proto_err),        32'(m_pe));
    check("rw_select",   32'(bus.buffer_rw_select), 32'(exp_rw()));
    check("full_cnt",    32'(bus.full_cnt),         32'(exp_full()));
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic fill_cycle(input int w);
    bus.fill_req = 1'b1;
    nxt();
    bus.fill_req = 1'b0; bus.fill_done = 1'b1; bus.fill_words = 7'(w);
    nxt();
    bus.fill_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.fill_req = 1'b0; bus.fill_done = 1'b0; bus.fill_words = '0;
    bus.drain_req = 1'b0; bus.drain_done = 1'b0; bus.abort = 1'b0;
    nxt(); nxt();
    check("rst_full_cnt", 32'(bus.full_cnt), 0);
    check("rst_rw_sel", 32'(bus.buffer_rw_select), 0);

    // First fill: grant the cycle after the first edge, buffer 0
    rst = 1'b0; bus.fill_req = 1'b1;
    nxt();
    check("g1_fill_grant", 32'(bus.fill_grant), 1);
    check("g1_fill_buf", 32'(bus.fill_buf), 0);
    check("g1_rw_sel", 32'(bus.buffer_rw_select), 1);
    bus.fill_req = 1'b0;
    nxt();
    check("g1_no_repeat", 32'(bus.fill_grant), 0);
    bus.fill_done = 1'b1; bus.fill_words = 7'd52;
    nxt();
    bus.fill_done = 1'b0;
    check("f1_full_cnt", 32'(bus.full_cnt), 1);

    // Same-cycle fill and drain grants
    bus.fill_req = 1'b1; bus.drain_req = 1'b1;
    nxt();
    check("dual_fill_grant", 32'(bus.fill_grant), 1);
    check("dual_drain_grant", 32'(bus.drain_grant), 1);
    check("dual_drain_buf", 32'(bus.drain_buf), 0);
    check("dual_drain_words", 32'(bus.drain_words), 52);
    check("dual_fill_buf", 32'(bus.fill_buf), 1);
    bus.fill_req = 1'b0; bus.drain_req = 1'b0;

    // Simultaneous completions on different buffers
    bus.fill_done = 1'b1; bus.fill_words = 7'd20; bus.drain_done = 1'b1;
    nxt();
    bus.fill_done = 1'b0; bus.drain_done = 1'b0;
    check("simul_full_cnt", 32'(bus.full_cnt), 1);
    check("simul_proto", 32'(bus.proto_err), 0);

    // Abort, then both full: fill must wait for a drain to finish
    bus.abort = 1'b1;
    nxt();
    bus.abort = 1'b0;
    check("abort_full_cnt", 32'(bus.full_cnt), 0);
    fill_cycle(5);
    fill_cycle(6);
    check("both_full", 32'(bus.full_cnt), 2);
    bus.fill_req = 1'b1;
    nxt();
    check("blocked_a", 32'(bus.fill_grant), 0);
    nxt();
    check("blocked_b", 32'(bus.fill_grant), 0);
    bus.drain_req = 1'b1;
    nxt();
    check("d_grant", 32'(bus.drain_grant), 1);
    check("d_buf", 32'(bus.drain_buf), 0);
    check("d_words", 32'(bus.drain_words), 5);
    bus.drain_req = 1'b0; bus.drain_done = 1'b1;
    nxt();
    bus.drain_done = 1'b0;
    check("no_bypass", 32'(bus.fill_grant), 0);
    nxt();
    check("late_grant", 32'(bus.fill_grant), 1);
    check("late_buf", 32'(bus.fill_buf), 0);
    bus.fill_req = 1'b0;

    // Zero-word fill returns the buffer and keeps the pointer
    bus.fill_done = 1'b1; bus.fill_words = 7'd0;
    nxt();
    bus.fill_done = 1'b0;
    check("zero_rw_sel", 32'(bus.buffer_rw_select), 0);
    check("zero_full_cnt", 32'(bus.full_cnt), 1);
    bus.fill_req = 1'b1;
    nxt();
    check("reuse_grant", 32'(bus.fill_grant), 1);
    check("reuse_buf", 32'(bus.fill_buf), 0);
    bus.fill_req = 1'b0; bus.fill_done = 1'b1; bus.fill_words = 7'd7;
    nxt();
    bus.fill_done = 1'b0;
    check("refill_full_cnt", 32'(bus.full_cnt), 2);

    // Stray drain_done, then abort keeps the sticky error
    bus.drain_done = 1'b1;
    nxt();
    bus.drain_done = 1'b0;
    check("stray_proto", 32'(bus.proto_err), 1);
    check("stray_full_cnt", 32'(bus.full_cnt), 2);
    bus.abort = 1'b1; bus.fill_req = 1'b1;
    nxt();
    check("abort_wins_grant", 32'(bus.fill_grant), 0);
    check("abort2_full_cnt", 32'(bus.full_cnt), 0);
    check("abort2_proto", 32'(bus.proto_err), 1);
    bus.abort = 1'b0;
    nxt();
    check("post_abort_grant", 32'(bus.fill_grant), 1);
    check("post_abort_buf", 32'(bus.fill_buf), 0);
    bus.fill_req = 1'b0;

    // Asynchronous reset in the middle of a fill
    #3 rst = 1'b1;
    #1;
    check("arst_fill_grant", 32'(bus.fill_grant), 0);
    check("arst_rw_sel", 32'(bus.buffer_rw_select), 0);
    check("arst_proto", 32'(bus.proto_err), 0);
    nxt();
    rst = 1'b0; bus.fill_done = 1'b1; bus.fill_words = 7'd3;
    nxt();
    bus.fill_done = 1'b0;
    check("late_done_proto", 32'(bus.proto_err), 1);
    check("late_done_full", 32'(bus.full_cnt), 0);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
